// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - gshare direction predictor with tagged BTB and repairable global history
//
// Purpose:
//   Combinational next-PC prediction for the fetch stage. Direction comes from a
//   table of 2-bit saturating counters indexed by pc XOR global history. Targets
//   come from a direct-mapped, tagged BTB. The global history register is shifted
//   speculatively on every predicted branch and repaired from the snapshot the
//   branch carried when a misprediction resolves.
//
// Parameters:
//   XLEN        address width
//   BHT_ENTRIES number of 2-bit counters (power of 2)
//   BTB_ENTRIES number of BTB entries (power of 2, at least 2)
//   GHR_BITS    global history length, 1 .. log2(BHT_ENTRIES)
//
// Ports:
//   clk                  clock, all state changes on the rising edge
//   rst_n                asynchronous active-low reset
//   i_fetch_valid        i_pc_fetch is a real fetch this cycle
//   i_pc_fetch           fetch address
//   o_predict_taken      predicted direction
//   o_predict_target     predicted next PC
//   o_predict_hit        BTB hit for i_pc_fetch
//   o_predict_ghr        current speculative history, carried with the branch
//   i_update_valid       a branch resolved this cycle
//   i_update_pc          resolved branch PC
//   i_update_target      resolved branch target
//   i_update_taken       resolved direction
//   i_update_ghr         o_predict_ghr captured when the branch was predicted
//   i_update_mispredict  direction or target was wrong; repairs the history

module branch_predictor_gshare #(
   parameter int XLEN        = 64,
   parameter int BHT_ENTRIES = 256,
   parameter int BTB_ENTRIES = 32,
   parameter int GHR_BITS    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_fetch_valid,
   input  logic [XLEN-1:0]     i_pc_fetch,
   output logic                o_predict_taken,
   output logic [XLEN-1:0]     o_predict_target,
   output logic                o_predict_hit,
   output logic [GHR_BITS-1:0] o_predict_ghr,
   input  logic                i_update_valid,
   input  logic [XLEN-1:0]     i_update_pc,
   input  logic [XLEN-1:0]     i_update_target,
   input  logic                i_update_taken,
   input  logic [GHR_BITS-1:0] i_update_ghr,
   input  logic                i_update_mispredict
);

   localparam int B     = $clog2(BHT_ENTRIES);
   localparam int T     = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - T - 2;

   localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

   // History is zero-extended to the index width before the XOR.
   function automatic logic [B-1:0] f_ghr_ext(input logic [GHR_BITS-1:0] ghr);
      logic [B-1:0] ext;
      ext                 = '0;
      ext[GHR_BITS-1:0]   = ghr;
      return ext;
   endfunction

   logic [1:0]             r_bht        [BHT_ENTRIES];
   logic [BTB_ENTRIES-1:0] r_btb_valid;
   logic [TAG_W-1:0]       r_btb_tag    [BTB_ENTRIES];
   logic [XLEN-1:0]        r_btb_target [BTB_ENTRIES];
   logic [GHR_BITS-1:0]    r_ghr;

   logic [B-1:0]           w_fetch_bht_idx;
   logic [T-1:0]           w_fetch_btb_idx;
   logic [TAG_W-1:0]       w_fetch_tag;
   logic                   w_hit;
   logic                   w_taken;

   logic [B-1:0]           w_upd_bht_idx;
   logic [T-1:0]           w_upd_btb_idx;
   logic [TAG_W-1:0]       w_upd_tag;
   logic [1:0]             w_upd_ctr;
   logic [1:0]             w_upd_ctr_next;

   logic [GHR_BITS-1:0]    w_spec_ghr;
   logic [GHR_BITS-1:0]    w_repair_ghr;

   // Byte-offset bits of the resolved PC never reach any index or tag.
   logic                   w_unused;
   assign w_unused = ^i_update_pc[1:0];

   // ---------------- prediction (reads state before any same-cycle write) ----
   assign w_fetch_bht_idx = i_pc_fetch[B+1:2] ^ f_ghr_ext(r_ghr);
   assign w_fetch_btb_idx = i_pc_fetch[T+1:2];
   assign w_fetch_tag     = i_pc_fetch[XLEN-1:T+2];

   assign w_hit   = r_btb_valid[w_fetch_btb_idx] &&
                    (r_btb_tag[w_fetch_btb_idx] == w_fetch_tag);
   assign w_taken = w_hit & r_bht[w_fetch_bht_idx][1];

   assign o_predict_hit    = w_hit;
   assign o_predict_taken  = w_taken;
   assign o_predict_target = w_taken ? r_btb_target[w_fetch_btb_idx]
                                     : i_pc_fetch + PC_STEP;
   assign o_predict_ghr    = r_ghr;

   // ---------------- update side indices ----------------
   assign w_upd_bht_idx = i_update_pc[B+1:2] ^ f_ghr_ext(i_update_ghr);
   assign w_upd_btb_idx = i_update_pc[T+1:2];
   assign w_upd_tag     = i_update_pc[XLEN-1:T+2];
   assign w_upd_ctr     = r_bht[w_upd_bht_idx];

   always_comb begin
      w_upd_ctr_next = w_upd_ctr;
      if (i_update_taken) begin
         if (w_upd_ctr != 2'b11) w_upd_ctr_next = w_upd_ctr + 2'b01;
      end else begin
         if (w_upd_ctr != 2'b00) w_upd_ctr_next = w_upd_ctr - 2'b01;
      end
   end

   // A one-bit history has nothing to shift; it is just the newest outcome.
   generate
      if (GHR_BITS == 1) begin : g_ghr_one
         assign w_spec_ghr   = w_taken;
         assign w_repair_ghr = i_update_taken;
      end else begin : g_ghr_many
         assign w_spec_ghr   = {r_ghr[GHR_BITS-2:0], w_taken};
         assign w_repair_ghr = {i_update_ghr[GHR_BITS-2:0], i_update_taken};
      end
   endgenerate

   // ---------------- state ----------------
   // Repair rebuilds history from the mispredicted branch's snapshot, so it
   // overrides whatever the wrong-path fetch would have shifted in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ghr <= '0;
      end else if (i_update_valid && i_update_mispredict) begin
         r_ghr <= w_repair_ghr;
      end else if (i_fetch_valid && w_hit) begin
         r_ghr <= w_spec_ghr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            r_bht[i] <= 2'b01;
         end
      end else if (i_update_valid) begin
         r_bht[w_upd_bht_idx] <= w_upd_ctr_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btb_valid <= '0;
      end else if (i_update_valid && i_update_taken) begin
         r_btb_valid[w_upd_btb_idx] <= 1'b1;
      end
   end

   // Tag and target payload are only meaningful behind a valid bit, so they
   // carry no reset.
   always_ff @(posedge clk) begin
      if (i_update_valid && i_update_taken) begin
         r_btb_tag[w_upd_btb_idx]    <= w_upd_tag;
         r_btb_target[w_upd_btb_idx] <= i_update_target;
      end
   end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - scoreboard bench for branch_predictor_gshare

module tb_branch_predictor_gshare;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_valid;
   logic [63:0] pc_fetch;
   logic        predict_taken;
   logic [63:0] predict_target;
   logic        predict_hit;
   logic [7:0]  predict_ghr;
   logic        update_valid;
   logic [63:0] update_pc;
   logic [63:0] update_target;
   logic        update_taken;
   logic [7:0]  update_ghr;
   logic        update_mispredict;

   always #5 clk = ~clk;

   branch_predictor_gshare #(
      .XLEN        (64),
      .BHT_ENTRIES (256),
      .BTB_ENTRIES (32),
      .GHR_BITS    (8)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .i_fetch_valid       (fetch_valid),
      .i_pc_fetch          (pc_fetch),
      .o_predict_taken     (predict_taken),
      .o_predict_target    (predict_target),
      .o_predict_hit       (predict_hit),
      .o_predict_ghr       (predict_ghr),
      .i_update_valid      (update_valid),
      .i_update_pc         (update_pc),
      .i_update_target     (update_target),
      .i_update_taken      (update_taken),
      .i_update_ghr        (update_ghr),
      .i_update_mispredict (update_mispredict)
   );

   typedef struct packed {
      logic        hit;
      logic        taken;
      logic [63:0] tgt;
      logic [7:0]  ghr;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   vec_no   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Monitor: every sampled fetch must match the oldest queued expectation.
   always @(negedge clk) begin
      if (fetch_valid) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow: actual=fetch required=expectation");
         end else begin
            e = exp_q.pop_front();
            vec_no++;
            chk($sformatf("v%0d_hit", vec_no),    {63'd0, predict_hit},   {63'd0, e.hit});
            chk($sformatf("v%0d_taken", vec_no),  {63'd0, predict_taken}, {63'd0, e.taken});
            chk($sformatf("v%0d_target", vec_no), predict_target,         e.tgt);
            chk($sformatf("v%0d_ghr", vec_no),    {56'd0, predict_ghr},   {56'd0, e.ghr});
         end
      end
   end

   task automatic drive(input logic fv, input logic [63:0] pc,
                        input logic uv, input logic [63:0] upc, input logic [63:0] utgt,
                        input logic ut, input logic [7:0] ughr, input logic um,
                        input logic eh, input logic et, input logic [63:0] etgt,
                        input logic [7:0] eg);
      @(posedge clk);
      #1;
      fetch_valid       = fv;
      pc_fetch          = pc;
      update_valid      = uv;
      update_pc         = upc;
      update_target     = utgt;
      update_taken      = ut;
      update_ghr        = ughr;
      update_mispredict = um;
      if (fv) exp_q.push_back('{hit: eh, taken: et, tgt: etgt, ghr: eg});
   endtask

   task automatic fetch(input logic [63:0] pc, input logic eh, input logic et,
                        input logic [63:0] etgt, input logic [7:0] eg);
      drive(1'b1, pc, 1'b0, 64'd0, 64'd0, 1'b0, 8'd0, 1'b0, eh, et, etgt, eg);
   endtask

   task automatic upd(input logic [63:0] upc, input logic [63:0] utgt, input logic ut,
                      input logic [7:0] ughr, input logic um);
      drive(1'b0, 64'd0, 1'b1, upc, utgt, ut, ughr, um, 1'b0, 1'b0, 64'd0, 8'd0);
   endtask

   task automatic idle();
      drive(1'b0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0);
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      rst_n             = 1'b0;
      fetch_valid       = 1'b0;
      pc_fetch          = '0;
      update_valid      = 1'b0;
      update_pc         = '0;
      update_target     = '0;
      update_taken      = 1'b0;
      update_ghr        = '0;
      update_mispredict = 1'b0;

      repeat (2) @(posedge clk);
      // Outputs while held in reset
      fetch(64'h1000, 1'b0, 1'b0, 64'h1004, 8'h00);
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      fetch_valid = 1'b0;

      // Cold fetch: no hit, fall-through
      fetch(64'h1000, 1'b0, 1'b0, 64'h1004, 8'h00);
      // Allocate + repair: bht[0]=10, BTB[0] valid, GHR=01
      upd(64'h1000, 64'h2000, 1'b1, 8'h00, 1'b1);
      // Hit, index 1 still weakly not-taken; GHR shifts to 02
      fetch(64'h1000, 1'b1, 1'b0, 64'h1004, 8'h01);
      // Tag alias on BTB index 0
      fetch(64'h1080, 1'b0, 1'b0, 64'h1084, 8'h02);
      // Saturate index 0 at 11, then one not-taken repair -> 10, GHR=00
      for (int i = 0; i < 4; i++) upd(64'h1000, 64'h2000, 1'b1, 8'h00, 1'b0);
      upd(64'h1000, 64'hdead_0000, 1'b0, 8'h00, 1'b1);
      // Taken prediction to the stored target; GHR -> 01
      fetch(64'h1000, 1'b1, 1'b1, 64'h2000, 8'h00);
      // Index 1 not taken; GHR -> 02
      fetch(64'h1000, 1'b1, 1'b0, 64'h1004, 8'h01);
      // Repair to GHR=00 via an unrelated PC (bht[1] -> 00)
      upd(64'h3004, 64'h0, 1'b0, 8'h00, 1'b1);
      // Taken hit and repair in the same cycle: repair wins, GHR -> 1E
      drive(1'b1, 64'h1000, 1'b1, 64'h3008, 64'h0, 1'b0, 8'h0F, 1'b1,
            1'b1, 1'b1, 64'h2000, 8'h00);
      // Shows the repaired history; GHR -> 3C
      fetch(64'h1000, 1'b1, 1'b0, 64'h1004, 8'h1E);
      // Read-before-write: fetch sees old BTB, update allocates 0x1080 and trains idx 1C
      drive(1'b1, 64'h1080, 1'b1, 64'h1080, 64'h5000, 1'b1, 8'h3C, 1'b0,
            1'b0, 1'b0, 64'h1084, 8'h3C);
      // New entry visible next cycle; GHR -> 79
      fetch(64'h1080, 1'b1, 1'b1, 64'h5000, 8'h3C);
      // Old occupant 0x1000 was overwritten
      fetch(64'h1000, 1'b0, 1'b0, 64'h1004, 8'h79);

      // Asynchronous reset between edges
      @(posedge clk);
      #1;
      fetch_valid  = 1'b1;
      pc_fetch     = 64'h1080;
      update_valid = 1'b0;
      exp_q.push_back('{hit: 1'b0, taken: 1'b0, tgt: 64'h1084, ghr: 8'h00});
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      fetch_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reallocate 0x1000 while training only idx 1; idx 0 must be back at 01
      upd(64'h1000, 64'h2000, 1'b1, 8'h01, 1'b0);
      fetch(64'h1000, 1'b1, 1'b0, 64'h1004, 8'h00);
      fetch(64'h1000, 1'b1, 1'b0, 64'h1004, 8'h00);
      idle();
      idle();
      idle();

      chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, giving the address width.
REQ-002 The module SHALL have parameter BHT_ENTRIES, default 256, giving the count of 2-bit counters (power of 2).
REQ-003 The module SHALL have parameter BTB_ENTRIES, default 32, giving the count of tagged BTB entries (power of 2).
REQ-004 The module SHALL have parameter GHR_BITS, default 8, giving the global history length; it SHALL satisfy 1 <= GHR_BITS <= log2(BHT_ENTRIES).
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 fetch_valid  in  1  pc_fetch is a real fetch this cycle.
REQ-008 pc_fetch  in  XLEN  fetch address.
REQ-009 predict_taken  out  1  predicted direction.
REQ-010 predict_target  out  XLEN  predicted next PC.
REQ-011 predict_hit  out  1  BTB hit for pc_fetch.
REQ-012 predict_ghr  out  GHR_BITS  current speculative history; the front end carries it with the branch.
REQ-013 update_valid  in  1  branch resolved this cycle.
REQ-014 update_pc, update_target  in  XLEN each  resolved branch PC and actual target.
REQ-015 update_taken  in  1  actual direction.
REQ-016 update_ghr  in  GHR_BITS  predict_ghr value captured when this branch was predicted.
REQ-017 update_mispredict  in  1  direction or target was wrong; triggers history repair.

Function
REQ-018 Index definitions SHALL be as follows, with B = log2(BHT_ENTRIES) and T = log2(BTB_ENTRIES):
- BHT index = pc[B+1:2] XOR zero-extended GHR.
- BTB index = pc[T+1:2].
- Tag = pc[XLEN-1:T+2].
REQ-019 A prediction SHALL be combinational in the same cycle as pc_fetch, using the current GHR.
REQ-020 predict_hit SHALL be 1 when valid[btb_idx] = 1 and the stored tag equals the pc_fetch tag.
REQ-021 predict_taken SHALL equal predict_hit AND bht[idx][1]; without a BTB hit, the prediction is never taken.
REQ-022 predict_target SHALL be the stored target when predict_taken = 1, else pc_fetch + 4 (modulo 2^XLEN).
REQ-023 Speculative history update: when fetch_valid = 1 and predict_hit = 1, the GHR SHALL become {GHR[GHR_BITS-2:0], predict_taken} at the next edge.
REQ-024 Repair: when update_valid = 1 and update_mispredict = 1, the GHR SHALL become {update_ghr[GHR_BITS-2:0], update_taken}. Repair SHALL take priority over a same-cycle fetch shift.
REQ-025 For GHR_BITS = 1, the shifted value SHALL be the new bit alone.
REQ-026 Counter update: when update_valid = 1, the counter at index (update_pc, update_ghr) SHALL increment on taken and decrement on not-taken, saturating at 2'b11 and 2'b00.
REQ-027 BTB allocation: when update_valid = 1 and update_taken = 1, the entry at update_pc's BTB index SHALL be written with valid = 1, the tag and update_target, overwriting any previous occupant.
REQ-028 A not-taken update SHALL leave the BTB unchanged.
REQ-029 Same-cycle fetch and update to the same entry SHALL be read-before-write: the prediction sees the old value and the update is visible from the next cycle.
REQ-030 When update_valid = 0, no counter or BTB state SHALL change; GHR changes only per REQ-023.

Reset
REQ-031 While rst_n = 0, regardless of clk, the block SHALL set all counters to 2'b01, all BTB valid bits to 0 and GHR to 0.
REQ-032 As a result of REQ-031, during and after reset the outputs SHALL be predict_hit = 0, predict_taken = 0, predict_target = pc_fetch + 4 and predict_ghr = 0.
REQ-033 Reset asserted mid-operation SHALL discard all learned state; the BTB target and tag arrays need not be cleared.

Verification (defaults: XLEN = 64, BHT = 256, BTB = 32, GHR = 8)
REQ-034 Reset, then pc_fetch = 0x1000 -> hit 0, taken 0, target 0x1004, ghr 0x00.
REQ-035 Update 0x1000, taken, target 0x2000, update_ghr 0, mispredict 1 -> bht[0] = 2'b10, BTB[0] valid, GHR 0x01.
- Then fetch 0x1000 -> hit 1, taken 0 (bht[1] = 2'b01), target 0x1004.
- GHR becomes 0x02 at the next edge.
REQ-036 Saturation: four taken updates to index 0 -> 2'b11; one not-taken -> 2'b10.
- A fetch with GHR 0 then predicts taken to the stored target.
REQ-037 Tag alias: with BTB entry 0 holding 0x1000, fetch 0x1080 (same BTB index, different tag) -> hit 0, taken 0, target 0x1084.
REQ-038 Same cycle: fetch hit predicting taken plus mispredict repair with update_ghr 0x0F and update_taken 0 -> GHR 0x1E (repair wins).
REQ-039 Assert rst_n low between clk edges after training -> all counters 2'b01, BTB valid bits and GHR cleared immediately.
- A fetch of 0x1000 during reset gives hit 0, target 0x1004.
